// File: rtl/render_line_scheduler.sv
// Per-scanline sprite pipeline sequencer: schedules prepare/draw one line ahead of the raster and arbitrates OAM.
// Latency: start/abort/swap/overrun pulses are registered, one cycle after the triggering raster position or done input.
// Backpressure: none; prepare and draw stages hand back completion on prep_done/draw_done, and a missed line boundary is flagged as overrun.
// Optional statistics (overrun_count, max_latency, stats_clr) are compiled in with RENDER_SCHED_STATS_EN.
module render_line_scheduler #(
    parameter int H_TOTAL       = 800,
    parameter int V_TOTAL       = 525,
    parameter int V_RES         = 480,
    parameter int CORDW         = 10,
    parameter int OAM_ADDR_SIZE = 6
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     enable,
    input  logic [CORDW-1:0]         sx,
    input  logic [CORDW-1:0]         sy,
    output logic                     prep_start,
    input  logic                     prep_done,
    output logic                     draw_start,
    input  logic                     draw_done,
    output logic                     abort,
    output logic [CORDW-1:0]         target_line,
    input  logic [OAM_ADDR_SIZE-1:0] oam_addr_prep,
    input  logic [OAM_ADDR_SIZE-1:0] oam_addr_draw,
    output logic [OAM_ADDR_SIZE-1:0] oam_addr,
    output logic                     swap,
    output logic                     overrun,
    output logic                     busy
`ifdef RENDER_SCHED_STATS_EN
    ,
    input  logic                     stats_clr,
    output logic [15:0]              overrun_count,
    output logic [CORDW:0]           max_latency
`endif
);

    typedef enum logic [1:0] {IDLE, PREP, DRAW, READY} state_t;

    localparam logic [CORDW-1:0] H_LAST = CORDW'(H_TOTAL - 1);
    localparam logic [CORDW-1:0] V_LAST = CORDW'(V_TOTAL - 1);
    localparam logic [CORDW-1:0] V_VIS  = CORDW'(V_RES);

    state_t           state;
    logic             first_cyc;   // high during the first cycle of PREP or DRAW
    logic             line_start;
    logic             boundary;
    logic [CORDW-1:0] next_y;
    logic             sched_now;
    logic             prep_accept;
    logic             draw_accept;

    // Raster decode and the events that move the state machine this cycle
    always_comb begin
        line_start  = (sx == '0);
        boundary    = (sx == H_LAST);
        next_y      = (sy == V_LAST) ? '0 : sy + CORDW'(1);
        // boundary outranks everything, including a line_start on a degenerate raster
        sched_now   = line_start && enable && (next_y < V_VIS) && !boundary;
        // the first cycle of each stage masks a done level left over from the previous line
        prep_accept = (state == PREP) && !first_cyc && prep_done && !boundary && !sched_now;
        draw_accept = (state == DRAW) && !first_cyc && draw_done && !boundary && !sched_now;
    end

    // Line state machine with registered pulse outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            first_cyc   <= 1'b0;
            prep_start  <= 1'b0;
            draw_start  <= 1'b0;
            abort       <= 1'b0;
            swap        <= 1'b0;
            overrun     <= 1'b0;
            target_line <= '0;
        end else begin
            prep_start <= 1'b0;
            draw_start <= 1'b0;
            abort      <= 1'b0;
            swap       <= 1'b0;
            overrun    <= 1'b0;
            first_cyc  <= 1'b0;
            if (boundary) begin
                // end of line: a finished line is shown, an unfinished one is dropped
                case (state)
                    READY:      swap <= 1'b1;
                    PREP, DRAW: begin
                        overrun <= 1'b1;
                        abort   <= 1'b1;
                    end
                    default:    ;
                endcase
                state <= IDLE;
            end else if (sched_now) begin
                target_line <= next_y;
                prep_start  <= 1'b1;
                first_cyc   <= 1'b1;
                if ((state == PREP) || (state == DRAW)) begin
                    abort <= 1'b1;
                end
                state <= PREP;
            end else if (prep_accept) begin
                draw_start <= 1'b1;
                first_cyc  <= 1'b1;
                state      <= DRAW;
            end else if (draw_accept) begin
                state <= READY;
            end
        end
    end

    // The drawer owns OAM only while drawing; preparation owns it otherwise
    assign oam_addr = (state == DRAW) ? oam_addr_draw : oam_addr_prep;
    assign busy     = (state == PREP) || (state == DRAW);

`ifdef RENDER_SCHED_STATS_EN
    logic [CORDW:0] lat_cnt;
    logic [CORDW:0] lat_sat;

    // Latency of the line in flight, as it will read on entry into READY
    assign lat_sat = (lat_cnt == '1) ? lat_cnt : lat_cnt + 1'b1;

    // Overrun counter and worst-case prepare-to-ready latency; clear beats a same-cycle update
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_cnt       <= '0;
            overrun_count <= '0;
            max_latency   <= '0;
        end else begin
            if (sched_now) begin
                lat_cnt <= '0;
            end else if (busy) begin
                lat_cnt <= lat_sat;
            end
            if (stats_clr) begin
                overrun_count <= '0;
                max_latency   <= '0;
            end else begin
                if (boundary && busy && (overrun_count != 16'hFFFF)) begin
                    overrun_count <= overrun_count + 16'd1;
                end
                if (draw_accept && (lat_sat > max_latency)) begin
                    max_latency <= lat_sat;
                end
            end
        end
    end
`endif

endmodule

// File: doc/render_line_scheduler.md
Name: render_line_scheduler

Overview:
Sequences the per-scanline sprite pipeline (line preparation, then sprite drawing) one line ahead of the raster.
- Generates start, abort and swap pulses from the sx/sy raster position.
- Arbitrates the single OAM read port between the preparation stage and the drawing stage.
- Flags lines whose pipeline did not finish before the line boundary (overrun).
- Sits between the display timing generator and the prepare/draw stages; replaces ad-hoc done-signal muxing in the display driver.

Parameters:
H_TOTAL, 800, total pixel clocks per line incl. blanking
V_TOTAL, 525, total lines per frame incl. blanking
V_RES, 480, visible lines
CORDW, 10, raster coordinate width
OAM_ADDR_SIZE, 6, OAM read address width

Ports:
clk  in  1  pixel clock; only clock
rst  in  1  synchronous, active-high reset
enable  in  1  allow scheduling of new lines
sx  in  CORDW  current raster x
sy  in  CORDW  current raster y
prep_start  out  1  one-cycle start pulse to line preparation
prep_done  in  1  preparation finished (level or pulse)
draw_start  out  1  one-cycle start pulse to sprite drawer
draw_done  in  1  drawer finished (level or pulse)
abort  out  1  one-cycle pulse: abandon in-flight line
target_line  out  CORDW  line being prepared/drawn (registered)
oam_addr_prep  in  OAM_ADDR_SIZE  OAM address from preparation
oam_addr_draw  in  OAM_ADDR_SIZE  OAM address from drawer
oam_addr  out  OAM_ADDR_SIZE  muxed OAM read address
swap  out  1  one-cycle pulse: promote back buffer to display buffer
overrun  out  1  one-cycle pulse: line missed its deadline
busy  out  1  state is PREP or DRAW

Behaviour:
- States: IDLE, PREP, DRAW, READY. All registered. Reset → IDLE.
- On reset, all outputs are 0: prep_start, draw_start, abort, swap, overrun, busy, target_line.
- line_start = (sx == 0). boundary = (sx == H_TOTAL-1).
- next_y = (sy == V_TOTAL-1) ? 0 : sy+1. Compute at CORDW width; no overflow at V_TOTAL-1.
- On line_start, if enable=1 and next_y < V_RES:
  - target_line <= next_y, prep_start = 1 on the following cycle (latency 1), state → PREP.
  - If state is PREP or DRAW at that moment, abort pulses in the same cycle as prep_start.
  - Otherwise no schedule is made; state is unchanged.
- PREP:
  - prep_done is ignored in the first cycle of PREP (masks a stale level).
  - On the first later cycle with prep_done=1: draw_start pulses next cycle, state → DRAW.
- DRAW:
  - draw_done is ignored in the first cycle of DRAW.
  - On a later draw_done=1: state → READY.
- On boundary:
  - READY: swap pulses next cycle, state → IDLE.
  - PREP or DRAW: overrun pulses next cycle, abort pulses next cycle, no swap, state → IDLE.
  - IDLE: nothing.
- Priority within a cycle: boundary > done input. A done arriving on the boundary cycle is an overrun.
- oam_addr = oam_addr_draw when state==DRAW, else oam_addr_prep. Combinational from registered state.
- busy = (state==PREP || state==DRAW).
- Lines with target ≥ V_RES (vertical blank) are never scheduled and never swapped.
- Line V_TOTAL-1 schedules target 0.
- enable falling mid-line: the in-flight line completes normally; the next line_start does not schedule.
- Reset mid-operation: immediate IDLE on the next edge. No abort/swap/overrun pulse is generated by reset.
- Only one of swap/overrun pulses per line.

Optional Feature:
- Macro: RENDER_SCHED_STATS_EN.
- When defined, adds output ports:
  - overrun_count (16-bit): saturates at 16'hFFFF, +1 per overrun pulse.
  - max_latency (CORDW+1 bits): largest cycle count from prep_start to entry into READY, over all completed lines.
  - stats_clr (input, 1): synchronously zeroes both; clear wins over a same-cycle increment.
- Both reset to 0.
- When undefined, these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Nominal: sy=10, sx=0, enable=1 → prep_start at sx=1, target_line=11. prep_done at sx=50 → draw_start at sx=51. draw_done at sx=400 → swap at sx=0 of line 11, no overrun.
- Wrap and blank: sy=524, sx=0 → target_line=0, prep_start. sy=479 and sy=480..523 at sx=0 → no prep_start, no swap.
- Overrun: start line 20, hold draw_done=0 through sx=799 → overrun=1 and abort=1 at the next cycle, swap=0, state IDLE, busy=0.
- Stale level: prep_done held high continuously → draw_start occurs exactly 2 cycles after prep_start, never in the same cycle.
- OAM mux: oam_addr_prep=6'h05, oam_addr_draw=6'h2A → oam_addr=6'h05 in PREP/IDLE/READY, 6'h2A in DRAW.
- Reset mid-DRAW at sx=200: rst=1 for one cycle → all outputs 0, state IDLE; the next sx=0 reschedules normally. With RENDER_SCHED_STATS_EN: three forced overruns → overrun_count=3; stats_clr → 0.
